// File: rtl/fecg_mat_pkg.sv
// Shared types and default dimensions for the fetal ECG matrix datapath.
package fecg_mat_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    localparam int unsigned DEF_SIZE_A = 8;
    localparam int unsigned DEF_SIZE_B = 8;
    localparam int unsigned DEF_N_BITS = 22;

endpackage

// File: rtl/scalar_mult_elem.sv
// Single-element signed fixed-point multiply: full 2*N_BITS product,
// shifted right by FRAC_BITS and truncated to N_BITS (wraps on overflow).
module scalar_mult_elem #(
    parameter int unsigned N_BITS    = 22,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] p
);

    logic [2*N_BITS-1:0] a_ext;
    logic [2*N_BITS-1:0] b_ext;

    // Sign-extending to the full product width makes the low 2*N_BITS of
    // an unsigned multiply equal the two's-complement product.
    assign a_ext = {{N_BITS{a[N_BITS-1]}}, a};
    assign b_ext = {{N_BITS{b[N_BITS-1]}}, b};
    assign p     = N_BITS'((a_ext * b_ext) >> FRAC_BITS);

endmodule

// File: rtl/scalar_mat_scale_seq.sv
// Sequential scalar-by-matrix multiply: one multiplier lane walks all
// SIZE_A*SIZE_B elements in row-major order under a start/busy/done handshake.
module scalar_mat_scale_seq
    import fecg_mat_pkg::*;
#(
    parameter int unsigned SIZE_A    = DEF_SIZE_A,
    parameter int unsigned SIZE_B    = DEF_SIZE_B,
    parameter int unsigned N_BITS    = DEF_N_BITS,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [N_BITS-1:0]                scale,
    input  logic [SIZE_A*SIZE_B*N_BITS-1:0]  mat,
    output logic                             busy,
    output logic                             done,
    output logic                             out_valid,
    output logic [SIZE_A*SIZE_B*N_BITS-1:0]  mat_out
);

    localparam int unsigned RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int unsigned CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

    seq_state_t        state;
    seq_state_t        state_d;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [N_BITS-1:0] scale_q;
    logic [N_BITS-1:0] prod;
    logic              accept;
    logic              last;

    logic [N_BITS-1:0] mat_in [SIZE_A][SIZE_B];
    logic [N_BITS-1:0] mat_q  [SIZE_A][SIZE_B];
    logic [N_BITS-1:0] res_q  [SIZE_A][SIZE_B];

    // Flat row-major port vectors <-> internal 2-D arrays.
    for (genvar gi = 0; gi < SIZE_A; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE_B; gj++) begin : g_col
            assign mat_in[gi][gj] = mat[(gi*SIZE_B+gj)*N_BITS +: N_BITS];
            assign mat_out[(gi*SIZE_B+gj)*N_BITS +: N_BITS] = res_q[gi][gj];
        end
    end

    scalar_mult_elem #(
        .N_BITS    (N_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_mult (
        .a (mat_q[row][col]),
        .b (scale_q),
        .p (prod)
    );

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        last    = (row == ROW_LAST) && (col == COL_LAST);
        case (state)
            IDLE: begin
                accept  = start;
                state_d = start ? RUN : IDLE;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                accept  = start;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            scale_q   <= '0;
            out_valid <= 1'b0;
            mat_q     <= '{default: '0};
            res_q     <= '{default: '0};
        end else if (accept) begin
            row       <= '0;
            col       <= '0;
            scale_q   <= scale;
            mat_q     <= mat_in;
            out_valid <= 1'b0;
        end else if (state == RUN) begin
            res_q[row][col] <= prod;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (last) out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scalar_mat_scale_seq.sv
// Scoreboard bench: expected result matrices are queued at launch and popped
// by per-instance monitors on each done pulse.
module tb_scalar_mat_scale_seq;

    localparam int unsigned SA = 8;
    localparam int unsigned SB = 8;
    localparam int unsigned NB = 22;
    localparam int unsigned W  = SA * SB * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start0, start8;
    logic [NB-1:0] scale0, scale8;
    logic [W-1:0]  mat0, mat8, out0, out8;
    logic          busy0, done0, ov0, busy8, done8, ov8;

    logic [W-1:0]  q0[$];
    logic [W-1:0]  q8[$];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    scalar_mat_scale_seq #(
        .SIZE_A (SA), .SIZE_B (SB), .N_BITS (NB), .FRAC_BITS (0)
    ) u0 (
        .clk (clk), .rst_n (rst_n), .start (start0), .scale (scale0), .mat (mat0),
        .busy (busy0), .done (done0), .out_valid (ov0), .mat_out (out0)
    );

    scalar_mat_scale_seq #(
        .SIZE_A (SA), .SIZE_B (SB), .N_BITS (NB), .FRAC_BITS (8)
    ) u8 (
        .clk (clk), .rst_n (rst_n), .start (start8), .scale (scale8), .mat (mat8),
        .busy (busy8), .done (done8), .out_valid (ov8), .mat_out (out8)
    );

    function automatic logic [W-1:0] fill(input logic [NB-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < SA * SB; k++) r[k*NB +: NB] = v;
        return r;
    endfunction

    // Element (i,j) = k*(8*i+j), wrapped to NB bits.
    function automatic logic [W-1:0] ramp(input int k);
        logic [W-1:0] r;
        int           t;
        for (int e = 0; e < SA * SB; e++) begin
            t = k * e;
            r[e*NB +: NB] = t[NB-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkmat(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        int first;
        first = -1;
        for (int e = SA * SB - 1; e >= 0; e--)
            if (act[e*NB +: NB] !== exp[e*NB +: NB]) first = e;
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s: element [%0d][%0d] got %0h expected %0h", name,
                     first / SB, first % SB, act[first*NB +: NB], exp[first*NB +: NB]);
        end
    endtask

    always @(negedge clk) begin : mon0
        logic [W-1:0] e;
        if (rst_n === 1'b1 && done0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL u0_unexpected_done: got done=1 expected no pending job");
            end else begin
                e = q0.pop_front();
                chkmat("u0_result", out0, e);
                chk("u0_valid_at_done", ov0, 1);
            end
        end
    end

    always @(negedge clk) begin : mon8
        logic [W-1:0] e;
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL u8_unexpected_done: got done=1 expected no pending job");
            end else begin
                e = q8.pop_front();
                chkmat("u8_result", out8, e);
                chk("u8_valid_at_done", ov8, 1);
            end
        end
    end

    // Drives a one-cycle start, then scrambles the operands to prove isolation.
    task automatic launch(input bit sel, input logic [NB-1:0] s, input logic [W-1:0] m);
        if (!sel) begin scale0 = s; mat0 = m; start0 = 1'b1; end
        else      begin scale8 = s; mat8 = m; start8 = 1'b1; end
        @(posedge clk); #1;
        if (!sel) begin start0 = 1'b0; scale0 = ~s; mat0 = ~m; end
        else      begin start8 = 1'b0; scale8 = ~s; mat8 = ~m; end
    endtask

    task automatic wait_done(input bit sel, output int cyc, output int nb);
        cyc = 0;
        nb  = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if ((sel ? done8 : done0) === 1'b1) return;
            if ((sel ? busy8 : busy0) === 1'b1) nb++;
        end
        total++; bad++;
        $display("FAIL u%0d_done_timeout: got no done within %0d cycles expected done", sel ? 8 : 0, cyc);
    endtask

    initial begin
        int cyc, nb;
        rst_n = 1'b0;
        start0 = 1'b0; start8 = 1'b0;
        scale0 = '0; scale8 = '0; mat0 = '0; mat8 = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_valid0", ov0, 0);
        chkmat("rst_out0", out0, '0);
        chk("rst_busy8", busy8, 0);
        chk("rst_valid8", ov8, 0);
        chkmat("rst_out8", out8, '0);

        // Identity scaling with timing checks.
        q0.push_back(ramp(1));
        launch(0, 22'h000001, ramp(1));
        wait_done(0, cyc, nb);
        chk("ident_done_cycle", cyc, 65);
        chk("ident_busy_cycles", nb, 64);
        chk("ident_busy_at_done", busy0, 0);
        @(negedge clk);
        chk("ident_valid_after", ov0, 1);
        chk("ident_done_one_cycle", done0, 0);

        // Start mid-RUN must be ignored.
        q0.push_back(ramp(2));
        launch(0, 22'h000002, ramp(1));
        repeat (10) @(posedge clk);
        #1 scale0 = 22'h000005; mat0 = fill(22'h000007); start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done(0, cyc, nb);
        chk("ignore_done_cycle", cyc, 54);
        repeat (3) @(negedge clk);
        chk("ignore_no_rerun", busy0, 0);

        // Back-to-back: second start accepted in the DONE cycle.
        q0.push_back(fill(22'h3FFFFD));
        launch(0, 22'h000003, fill(22'h3FFFFF));
        wait_done(0, cyc, nb);
        q0.push_back(ramp(-1));
        launch(0, 22'h3FFFFF, ramp(1));
        @(negedge clk);
        chk("b2b_valid_drop", ov0, 0);
        chk("b2b_busy_no_bubble", busy0, 1);
        wait_done(0, cyc, nb);
        chk("b2b_done_cycle", cyc, 64);

        // Overflow wrap: 2 * -2^21 -> 0, 3 * -2^21 -> 0x200000.
        begin
            logic [W-1:0] m, e;
            m = fill(22'h000003);
            m[NB-1:0] = 22'h000002;
            e = fill(22'h200000);
            e[NB-1:0] = 22'h000000;
            q0.push_back(e);
            launch(0, 22'h200000, m);
            wait_done(0, cyc, nb);
        end

        // Reset mid-RUN.
        launch(0, 22'h000001, ramp(1));
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_valid", ov0, 0);
        chkmat("midrst_out", out0, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_idle", busy0, 0);
        q0.push_back(ramp(3));
        launch(0, 22'h000003, ramp(1));
        wait_done(0, cyc, nb);
        chk("postrst_done_cycle", cyc, 65);

        // Fixed point, FRAC_BITS=8: 1.5 * -1.0 and -1.0 * 2.0.
        q8.push_back(fill(22'h3FFE80));
        launch(1, 22'h000180, fill(22'h3FFF00));
        wait_done(1, cyc, nb);
        chk("fx_done_cycle", cyc, 65);
        q8.push_back(fill(22'h3FFE00));
        launch(1, 22'h3FFF00, fill(22'h000200));
        wait_done(1, cyc, nb);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q8_drained", q8.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scalar_mat_scale_seq.md
Name: scalar_mat_scale_seq

Overview:
- Sequential replacement for the fully parallel scalar-by-matrix multiply in the fetal ECG matrix datapath.
- Time-multiplexes one multiplier lane over all SIZE_A*SIZE_B elements, one element per cycle, in row-major order.
- Uses a start/busy/done handshake so the ICA control FSMs can schedule a scaling step without spending SIZE_A*SIZE_B multipliers.

Parameters:
- SIZE_A, 8: matrix rows.
- SIZE_B, 8: matrix columns.
- N_BITS, 22: element and scale width, two's-complement fixed point.
- FRAC_BITS, 0: right shift applied to the 2*N_BITS product before truncation. 0 gives plain low-N_BITS truncation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new scaling. Sampled only in IDLE or DONE.
- scale  in  N_BITS  scalar. Captured on an accepted start.
- mat  in  N_BITS x [SIZE_A][SIZE_B]  input matrix. Captured on an accepted start.
- busy  out  1  high while elements are being processed.
- done  out  1  one-cycle pulse when the last element has been written.
- out_valid  out  1  mat_out holds a complete result. Level signal.
- mat_out  out  N_BITS x [SIZE_A][SIZE_B]  registered result matrix.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, out_valid=0.
  - Row/column counters = 0.
  - Captured scale and matrix = 0; every mat_out element = 0.
- States:
  - IDLE: on start=1, capture scale and mat, clear out_valid, zero counters, go to RUN. Otherwise hold.
  - RUN: busy=1. Each cycle write mat_out[i][j] <= f(mat_q[i][j]*scale_q), then advance j. On j wrap (SIZE_B-1 -> 0), advance i. After element (SIZE_A-1,SIZE_B-1), go to DONE.
  - DONE: one cycle. done=1, busy=0, out_valid=1. Then go to IDLE.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back jobs, no bubble).
    - In that case out_valid drops again the next cycle.
- Timing: start sampled at edge t0. RUN covers cycles t0+1 .. t0+SIZE_A*SIZE_B. done is high in cycle t0+SIZE_A*SIZE_B+1 (65 cycles after start for 8x8).
- start while busy=1 is ignored. No queueing, no error flag.
- Operand isolation: mat and scale may change freely after acceptance. Only the captured copies are used.
- Arithmetic:
  - Full product p = signed(mat_q) * signed(scale_q), 2*N_BITS wide.
  - Result = p[FRAC_BITS+N_BITS-1 : FRAC_BITS]. Truncation, no rounding, no saturation; overflow wraps.
- mat_out during RUN:
  - Elements update progressively and are not coherent until out_valid=1.
  - Elements not yet rewritten keep their values from the previous job.
- mat_out after completion: holds until the next accepted start, then until overwritten.
- Counters: Clog2-sized. Row and column wrap back to 0 at the end of the job.
- Reset mid-RUN: immediate return to IDLE with all outputs at reset values. No done pulse.

Decomposition:
- Shared package (fecg_mat_pkg):
  - seq_state_t enum {IDLE, RUN, DONE}.
  - Default SIZE_A/SIZE_B/N_BITS constants.
- Sub-module scalar_mult_elem: combinational single-element signed multiply plus FRAC_BITS slice/truncate. Instantiated once.
- FSM, counters, capture registers and result array stay in the top module.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> busy=0, done=0, out_valid=0, all mat_out=0.
- Identity scaling: mat[i][j]=8*i+j, scale=1, start one cycle -> busy for exactly 64 cycles, done pulse at cycle 65, mat_out equals mat, out_valid=1 afterwards.
- Signed/fixed-point: FRAC_BITS=8, scale=0x000180 (1.5), mat all 0x3FFF00 (-1.0) -> every mat_out = 0x3FFE80 (-1.5). Scale=0x3FFF00 with mat 0x000200 -> 0x3FFE00.
- Overflow wrap: FRAC_BITS=0, scale=0x200000, mat[0][0]=2 -> mat_out[0][0]=0 (low 22 bits).
- Busy-ignore / back-to-back:
  - Pulse start again mid-RUN with a different mat -> ignored, result from first job.
  - Assert start during the DONE cycle -> new job starts with no idle cycle, out_valid low next cycle.
- Reset mid-operation: assert rst_n=0 at RUN element 20 -> busy=0, out_valid=0, mat_out all 0 immediately, no done pulse. A fresh start completes normally.
